// File: rtl/led_frame_buffer.sv
// Double-buffered 16-zone RGB frame store: writes land in a back bank, which is copied
// to the front bank on a start tick. Build with LED_FB_TEST_PATTERN_EN for a non-zero front reset pattern.
module led_frame_buffer #(
  parameter int ZONES        = 16,
  parameter int START_PERIOD = 2070000,
  parameter int EN_PERIOD    = 3000000
) (
  input  logic                 clk_fast,
  input  logic                 rstn,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [3:0]           wr_zone,
  input  logic [11:0]          wr_rgb,
  input  logic                 wr_last,
  output logic [ZONES*4-1:0]   MeanR,
  output logic [ZONES*4-1:0]   MeanG,
  output logic [ZONES*4-1:0]   MeanB,
  output logic                 start_o,
  output logic                 en_o
);

  localparam logic [21:0] START_LAST = 22'(START_PERIOD);
  localparam logic [21:0] EN_LAST    = 22'(EN_PERIOD);

  logic [21:0] start_cnt_q, start_cnt_d;
  logic [21:0] en_cnt_q, en_cnt_d;
  logic        pending_q, pending_d;
  logic        start_q, en_q;
  logic        start_tick, en_tick, wr_fire, swap;

  assign start_tick = (start_cnt_q == START_LAST);
  assign en_tick    = (en_cnt_q == EN_LAST);
  assign wr_ready   = ~pending_q;
  assign wr_fire    = wr_valid & wr_ready;
  // A frame completed on the tick edge itself waits for the next tick: swap looks only at the registered flag.
  assign swap       = start_tick & pending_q;
  assign start_o    = start_q;
  assign en_o       = en_q;

  always_comb begin
    start_cnt_d = start_tick ? 22'd0 : start_cnt_q + 22'd1;
    en_cnt_d    = en_tick ? 22'd0 : en_cnt_q + 22'd1;
    pending_d   = pending_q;
    if (swap) begin
      pending_d = 1'b0;
    end else if (wr_fire && wr_last) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      start_cnt_q <= '0;
      en_cnt_q    <= '0;
      pending_q   <= 1'b0;
      start_q     <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      start_cnt_q <= start_cnt_d;
      en_cnt_q    <= en_cnt_d;
      pending_q   <= pending_d;
      start_q     <= start_tick;
      en_q        <= en_tick;
    end
  end

  for (genvar gi = 0; gi < ZONES; gi++) begin : g_zone
`ifdef LED_FB_TEST_PATTERN_EN
    localparam logic [11:0] RST_RGB = {4'(gi), 4'(15 - gi), 4'h8};
`else
    localparam logic [11:0] RST_RGB = 12'h000;
`endif
    logic [11:0] back_q;
    logic [11:0] front_q;

    always_ff @(posedge clk_fast or negedge rstn) begin
      if (!rstn) begin
        back_q  <= 12'h000;
        front_q <= RST_RGB;
      end else begin
        if (wr_fire && (wr_zone == 4'(gi))) begin
          back_q <= wr_rgb;
        end
        if (swap) begin
          front_q <= back_q;
        end
      end
    end

    assign MeanR[gi*4 +: 4] = front_q[11:8];
    assign MeanG[gi*4 +: 4] = front_q[7:4];
    assign MeanB[gi*4 +: 4] = front_q[3:0];
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer with a scoreboard of expected start/en pulses and front-bank contents.
module tb_led_frame_buffer;

  logic         clk_fast = 1'b0;
  logic         rstn = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [3:0]   wr_zone = '0;
  logic [11:0]  wr_rgb = '0;
  logic         wr_last = 1'b0;
  logic [63:0]  MeanR, MeanG, MeanB;
  logic         start_o, en_o;

  led_frame_buffer #(.ZONES(16), .START_PERIOD(20), .EN_PERIOD(30)) dut (
    .clk_fast(clk_fast), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_zone(wr_zone), .wr_rgb(wr_rgb), .wr_last(wr_last),
    .MeanR(MeanR), .MeanG(MeanG), .MeanB(MeanB), .start_o(start_o), .en_o(en_o)
  );

  always #5 clk_fast = ~clk_fast;

  typedef struct { int cyc; logic [191:0] mean; } start_ev_t;
  start_ev_t    start_q[$];
  int           en_q[$];
  logic [191:0] exp_mean;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  function automatic logic [191:0] pack(input logic [11:0] z [16]);
    logic [63:0] r, g, b;
    for (int i = 0; i < 16; i++) begin
      r[i*4 +: 4] = z[i][11:8];
      g[i*4 +: 4] = z[i][7:4];
      b[i*4 +: 4] = z[i][3:0];
    end
    return {r, g, b};
  endfunction

  function automatic logic [191:0] pattern_mean();
    logic [11:0] z [16];
    for (int i = 0; i < 16; i++) begin
`ifdef LED_FB_TEST_PATTERN_EN
      z[i] = {4'(i), 4'(15 - i), 4'h8};
`else
      z[i] = 12'h000;
`endif
    end
    return pack(z);
  endfunction

  function automatic logic [191:0] custom_mean(input logic [11:0] base, input int zone, input logic [11:0] rgb);
    logic [11:0] z [16];
    for (int i = 0; i < 16; i++) z[i] = (i == zone) ? rgb : base;
    return pack(z);
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_start(input int c, input logic [191:0] m);
    start_ev_t ev;
    ev.cyc = c;
    ev.mean = m;
    start_q.push_back(ev);
  endtask

  // Advance one clock and check pulses and front bank against the scoreboard.
  task automatic clk1();
    logic exp_s, exp_e;
    @(posedge clk_fast);
    cyc++;
    @(negedge clk_fast);
    exp_s = (start_q.size() > 0) && (start_q[0].cyc == cyc);
    exp_e = (en_q.size() > 0) && (en_q[0] == cyc);
    chk("start_o", start_o, exp_s);
    chk("en_o", en_o, exp_e);
    if (exp_s) begin
      exp_mean = start_q[0].mean;
      void'(start_q.pop_front());
    end
    if (exp_e) void'(en_q.pop_front());
    chk("mean", {MeanR, MeanG, MeanB}, exp_mean);
  endtask

  task automatic drive(input logic v, input logic [3:0] z, input logic [11:0] rgb, input logic last);
    wr_valid = v;
    wr_zone  = z;
    wr_rgb   = rgb;
    wr_last  = last;
  endtask

  task automatic run_to(input int c);
    drive(1'b0, 4'd0, 12'h000, 1'b0);
    while (cyc < c) clk1();
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    drive(1'b0, 4'd0, 12'h000, 1'b0);
    #2;
    chk("rst_start_o", start_o, 1'b0);
    chk("rst_en_o", en_o, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_mean", {MeanR, MeanG, MeanB}, pattern_mean());
    @(negedge clk_fast);
    rstn = 1'b1;
    cyc = 0;
    start_q.delete();
    en_q.delete();
    exp_mean = pattern_mean();
  endtask

  task automatic phase_end(input string tag);
    chk({tag, "_start_left"}, start_q.size(), 0);
    chk({tag, "_en_left"}, en_q.size(), 0);
  endtask

  initial begin
    @(negedge clk_fast);

    // Free running, no writes: coincident ticks at cycle 651.
    do_reset();
    for (int k = 1; k <= 31; k++) push_start(21 * k, pattern_mean());
    for (int k = 1; k <= 21; k++) en_q.push_back(31 * k);
    run_to(651);
    chk("idle_wr_ready", wr_ready, 1'b1);
    phase_end("idle");

    // Full frame, then writes held off while pending.
    do_reset();
    push_start(21, custom_mean(12'hA5C, 0, 12'hA5C));
    push_start(42, custom_mean(12'hA5C, 1, 12'h777));
    push_start(63, custom_mean(12'hA5C, 1, 12'h777));
    en_q.push_back(31);
    en_q.push_back(62);
    for (int z = 0; z < 16; z++) begin
      drive(1'b1, 4'(z), 12'hA5C, z == 15);
      clk1();
    end
    chk("frame_wr_ready_low", wr_ready, 1'b0);
    while (cyc < 21) begin
      drive(1'b1, 4'd0, 12'hFFF, 1'b0);
      clk1();
      if (cyc < 21) chk("hold_wr_ready_low", wr_ready, 1'b0);
    end
    chk("swap_wr_ready_high", wr_ready, 1'b1);
    run_to(22);
    drive(1'b1, 4'd1, 12'h777, 1'b1);
    clk1();
    chk("z1_wr_ready_low", wr_ready, 1'b0);
    run_to(63);
    chk("frame_wr_ready_end", wr_ready, 1'b1);
    phase_end("frame");

    // wr_last accepted in the start-tick cycle defers the swap.
    do_reset();
    push_start(21, pattern_mean());
    push_start(42, custom_mean(12'h000, 3, 12'h123));
    push_start(63, custom_mean(12'h000, 3, 12'h123));
    en_q.push_back(31);
    en_q.push_back(62);
    run_to(20);
    drive(1'b1, 4'd3, 12'h123, 1'b1);
    clk1();
    chk("tick_wr_ready_low", wr_ready, 1'b0);
    run_to(42);
    chk("tick_wr_ready_high", wr_ready, 1'b1);
    run_to(63);
    phase_end("tick");

    // Mid-frame reset discards pending swap.
    do_reset();
    run_to(5);
    drive(1'b1, 4'd7, 12'hFFF, 1'b1);
    clk1();
    chk("mid_wr_ready_low", wr_ready, 1'b0);
    run_to(10);
    do_reset();
    push_start(21, pattern_mean());
    push_start(42, pattern_mean());
    en_q.push_back(31);
    run_to(43);
    chk("mid_wr_ready_end", wr_ready, 1'b1);
    phase_end("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
